// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: run / stop / single-step clock-enable controller for a CPU core.
// Define CPU_CLK_CTRL_DEBOUNCE_EN to add a DEB_CYCLES debouncer on the step button.
module cpu_clk_ctrl #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic [2:0]  div_sel,
  input  logic        halt_req,
  output logic        cpu_ce,
  output logic [1:0]  state,
  output logic [31:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_HALT    = 2'b00,
    ST_RUN     = 2'b01,
    ST_BREAK   = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_t;

  if (DEB_CYCLES < 2 || DEB_CYCLES > 65535) begin : g_bad_deb
    $error("cpu_clk_ctrl: DEB_CYCLES must be in 2..65535");
  end

  state_t      state_q;
  state_t      state_nx;
  logic        run_meta;
  logic        run_sync;
  logic        step_meta;
  logic        step_sync;
  logic [1:0]  step_valid;
  logic        step_cond;
  logic        step_prev;
  logic        step_armed;
  logic        step_rise;
  logic [31:0] presc;
  logic [31:0] presc_last;
  logic [2:0]  div_sel_q;
  logic        div_change;
  logic        tick;

  // step_valid marks when step_sync holds a real post-reset sample.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_meta   <= 1'b0;
      run_sync   <= 1'b0;
      step_meta  <= 1'b0;
      step_sync  <= 1'b0;
      step_valid <= 2'b00;
    end else begin
      run_meta   <= run_sw;
      run_sync   <= run_meta;
      step_meta  <= step_btn;
      step_sync  <= step_meta;
      step_valid <= {step_valid[0], 1'b1};
    end
  end

`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
  localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

  logic [15:0] deb_cnt;
  logic        deb_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt   <= 16'd0;
      deb_level <= 1'b0;
    end else if (step_sync == deb_level) begin
      deb_cnt <= 16'd0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_level <= step_sync;
      deb_cnt   <= 16'd0;
    end else begin
      deb_cnt <= deb_cnt + 16'd1;
    end
  end

  assign step_cond = deb_level;
`else
  assign step_cond = step_sync;
`endif

  // Edges count only once the button has been seen released after reset,
  // so a button held across reset release never produces a step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_prev  <= 1'b0;
      step_armed <= 1'b0;
      step_rise  <= 1'b0;
    end else begin
      step_prev <= step_cond;
      if (step_valid[1] && !step_sync && !step_cond)
        step_armed <= 1'b1;
      step_rise <= step_armed && step_cond && !step_prev;
    end
  end

  // NOTE: always_comb assigns a default first so no path infers a latch.
  always_comb begin
    state_nx = ST_HALT;
    case (state_q)
      ST_HALT:  state_nx = (run_sync && !halt_req) ? ST_RUN : ST_HALT;
      ST_RUN: begin
        if (halt_req)       state_nx = ST_BREAK;
        else if (!run_sync) state_nx = ST_HALT;
        else                state_nx = ST_RUN;
      end
      ST_BREAK: state_nx = run_sync ? ST_BREAK : ST_HALT;
      default:  state_nx = ST_HALT;
    endcase
  end

  assign div_change = (div_sel != div_sel_q);
  assign presc_last = (32'd1 << {div_sel, 1'b0}) - 32'd1;
  assign tick       = (state_q == ST_RUN) && !div_change && (presc == presc_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HALT;
      div_sel_q <= 3'd0;
      presc     <= 32'd0;
      cpu_ce    <= 1'b0;
      cycle_cnt <= 32'd0;
    end else begin
      state_q   <= state_nx;
      div_sel_q <= div_sel;
      if (state_q != ST_RUN || div_change || tick)
        presc <= 32'd0;
      else
        presc <= presc + 32'd1;
      // A tick coinciding with a RUN exit is dropped; steps are ignored in RUN.
      if (state_q == ST_RUN)
        cpu_ce <= tick && (state_nx == ST_RUN);
      else
        cpu_ce <= step_rise && (state_q == ST_HALT || state_q == ST_BREAK);
      cycle_cnt <= cycle_cnt + {31'd0, cpu_ce};
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed self-checking bench for cpu_clk_ctrl (default DEB_CYCLES=16).
// Build with CPU_CLK_CTRL_DEBOUNCE_EN defined to cover the debounced step path.
module tb_cpu_clk_ctrl;

`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
  localparam int LAT = 20;
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_sw;
  logic        step_btn;
  logic [2:0]  div_sel;
  logic        halt_req;
  logic        cpu_ce;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;

  int checks   = 0;
  int failures = 0;

  cpu_clk_ctrl #(.DEB_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_sw    (run_sw),
    .step_btn  (step_btn),
    .div_sel   (div_sel),
    .halt_req  (halt_req),
    .cpu_ce    (cpu_ce),
    .state     (state),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    run_sw   = 1'b0;
    step_btn = 1'b0;
    halt_req = 1'b0;
    div_sel  = 3'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Advance n rising edges, sampling 1 ns after each; report pulse count and first pulse index.
  task automatic run_edges(input int n, output int pulses, output int first);
    pulses = 0;
    first  = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (cpu_ce === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
  endtask

  // Wait (bounded) for the FSM to reach RUN; leaves time 1 ns after the entry edge.
  task automatic wait_run(input string name);
    bit found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(posedge clk);
      #1;
      if (state === 2'b01) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s: state=%b, required 01 within 12 cycles", name, state);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 2'b00 || cpu_ce !== 1'b0 || cycle_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: state=%b cpu_ce=%b cycle_cnt=%0d, required 00/0/0",
               state, cpu_ce, cycle_cnt);
    end
    do_reset();
  endtask

  task automatic test_step();
    int pulses, first;
    do_reset();
    @(negedge clk);
    step_btn = 1'b1;
    run_edges(LAT + 100, pulses, first);
    checks++;
    if (first !== LAT) begin
      failures++;
      $display("FAIL step_latency: first pulse at edge %0d, required %0d", first, LAT);
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL step_single: pulses=%0d, required 1", pulses);
    end
    checks++;
    if (cycle_cnt !== 32'd1 || state !== 2'b00) begin
      failures++;
      $display("FAIL step_count: cycle_cnt=%0d state=%b, required 1/00", cycle_cnt, state);
    end
    @(negedge clk);
    step_btn = 1'b0;
    run_edges(LAT + 6, pulses, first);
  endtask

`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
  task automatic test_debounce();
    int pulses, first, bounce_pulses;
    do_reset();
    bounce_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      step_btn = 1'b1;
      run_edges(3, pulses, first);
      bounce_pulses += pulses;
      @(negedge clk);
      step_btn = 1'b0;
      run_edges(3, pulses, first);
      bounce_pulses += pulses;
    end
    @(negedge clk);
    step_btn = 1'b1;
    run_edges(40, pulses, first);
    checks++;
    if (bounce_pulses !== 0 || pulses !== 1) begin
      failures++;
      $display("FAIL debounce_count: bounce=%0d stable=%0d, required 0/1", bounce_pulses, pulses);
    end
    checks++;
    if (first !== 20) begin
      failures++;
      $display("FAIL debounce_latency: first pulse at edge %0d, required 20", first);
    end
    @(negedge clk);
    step_btn = 1'b0;
    run_edges(LAT + 6, pulses, first);
  endtask
`endif

  task automatic test_run_rate();
    int pulses = 0;
    int pos[$];
    do_reset();
    @(negedge clk);
    div_sel = 3'd2;
    run_sw  = 1'b1;
    wait_run("run_entry");
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      if (cpu_ce === 1'b1) begin
        pulses++;
        pos.push_back(k);
      end
    end
    checks++;
    if (pulses !== 4) begin
      failures++;
      $display("FAIL run_pulses: pulses=%0d, required 4", pulses);
    end
    checks++;
    if (pos.size() != 4 || pos[0] != 16 || pos[1] != 32 || pos[2] != 48 || pos[3] != 64) begin
      failures++;
      $display("FAIL run_spacing: %0d pulses, first at %0d, required 16/32/48/64",
               pos.size(), (pos.size() > 0) ? pos[0] : 0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cycle_cnt !== 32'd4 || state !== 2'b01) begin
      failures++;
      $display("FAIL run_count: cycle_cnt=%0d state=%b, required 4/01", cycle_cnt, state);
    end
  endtask

  // Continues from RUN left by test_run_rate.
  task automatic test_break();
    int pulses, first;
    @(negedge clk);
    div_sel = 3'd0;
    run_edges(4, pulses, first);
    checks++;
    if (cpu_ce !== 1'b1) begin
      failures++;
      $display("FAIL div0_every_cycle: cpu_ce=%b, required 1", cpu_ce);
    end
    @(negedge clk);
    halt_req = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (state !== 2'b10 || cpu_ce !== 1'b0) begin
      failures++;
      $display("FAIL break_entry: state=%b cpu_ce=%b, required 10/0", state, cpu_ce);
    end
    @(negedge clk);
    halt_req = 1'b0;
    run_edges(8, pulses, first);
    checks++;
    if (state !== 2'b10 || pulses !== 0) begin
      failures++;
      $display("FAIL break_hold: state=%b pulses=%0d, required 10/0", state, pulses);
    end
    @(negedge clk);
    step_btn = 1'b1;
    run_edges(LAT + 5, pulses, first);
    checks++;
    if (pulses !== 1 || first !== LAT) begin
      failures++;
      $display("FAIL break_step: pulses=%0d first=%0d, required 1/%0d", pulses, first, LAT);
    end
    @(negedge clk);
    step_btn = 1'b0;
    run_edges(LAT + 6, pulses, first);
    @(negedge clk);
    run_sw = 1'b0;
    run_edges(2, pulses, first);
    checks++;
    if (state !== 2'b10) begin
      failures++;
      $display("FAIL break_exit_early: state=%b after 2 edges, required 10", state);
    end
    @(posedge clk);
    #1;
    checks++;
    if (state !== 2'b00) begin
      failures++;
      $display("FAIL break_exit: state=%b after 3 edges, required 00", state);
    end
  endtask

  task automatic test_step_in_run();
    int pulses, first;
    do_reset();
    @(negedge clk);
    div_sel = 3'd7;
    run_sw  = 1'b1;
    wait_run("run_entry_slow");
    @(negedge clk);
    step_btn = 1'b1;
    run_edges(LAT + 10, pulses, first);
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL step_in_run: pulses=%0d, required 0", pulses);
    end
    @(negedge clk);
    run_sw = 1'b0;
    run_edges(LAT + 10, pulses, first);
    checks++;
    if (pulses !== 0 || state !== 2'b00) begin
      failures++;
      $display("FAIL step_not_queued: pulses=%0d state=%b, required 0/00", pulses, state);
    end
    @(negedge clk);
    step_btn = 1'b0;
    run_edges(LAT + 6, pulses, first);
  endtask

  task automatic test_div_change();
    logic [8:0] mask;
    do_reset();
    @(negedge clk);
    div_sel = 3'd3;
    run_sw  = 1'b1;
    wait_run("run_entry_div3");
    repeat (10) @(negedge clk);
    div_sel = 3'd1;
    mask = '0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      mask[k-1] = cpu_ce;
    end
    checks++;
    if (mask !== 9'h110) begin
      failures++;
      $display("FAIL div_change: pulse mask=%b, required 100010000", mask);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses, first;
    do_reset();
    @(negedge clk);
    run_sw = 1'b1;
    wait_run("run_entry_div0");
    run_edges(3, pulses, first);
    @(negedge clk);
    rst_n    = 1'b0;
    run_sw   = 1'b0;
    step_btn = 1'b1;
    #1;
    checks++;
    if (cpu_ce !== 1'b0 || state !== 2'b00 || cycle_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_run: cpu_ce=%b state=%b cycle_cnt=%0d, required 0/00/0",
               cpu_ce, state, cycle_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_edges(LAT + 20, pulses, first);
    checks++;
    if (pulses !== 0 || state !== 2'b00) begin
      failures++;
      $display("FAIL held_across_reset: pulses=%0d state=%b, required 0/00", pulses, state);
    end
    @(negedge clk);
    step_btn = 1'b0;
    run_edges(LAT + 6, pulses, first);
    @(negedge clk);
    step_btn = 1'b1;
    run_edges(LAT + 4, pulses, first);
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL rearm_after_release: pulses=%0d, required 1", pulses);
    end
    @(negedge clk);
    step_btn = 1'b0;
    run_edges(LAT + 6, pulses, first);
  endtask

  task automatic test_back_to_back_wrap();
    int pulses, first;
    do_reset();
    @(negedge clk);
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    @(negedge clk);
    step_btn = 1'b1;
    run_edges(LAT + 3, pulses, first);
    checks++;
    if (cycle_cnt !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL wrap_first: cycle_cnt=%h, required ffffffff", cycle_cnt);
    end
    @(negedge clk);
    step_btn = 1'b0;
    run_edges(LAT + 6, pulses, first);
    @(negedge clk);
    step_btn = 1'b1;
    run_edges(LAT + 3, pulses, first);
    checks++;
    if (cycle_cnt !== 32'd0) begin
      failures++;
      $display("FAIL wrap_second: cycle_cnt=%h, required 00000000", cycle_cnt);
    end
    @(negedge clk);
    step_btn = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    run_sw   = 1'b0;
    step_btn = 1'b0;
    halt_req = 1'b0;
    div_sel  = 3'd0;
    test_reset();
    test_step();
`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
    test_debounce();
`endif
    test_run_rate();
    test_break();
    test_step_in_run();
    test_div_change();
    test_reset_mid_run();
    test_back_to_back_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
